// File: rtl/imuldiv_muldiv_arbiter_pkg.sv
// Mul/div request message layout, function codes and arbiter state encodings
// shared by the arbiter and its users.
package imuldiv_muldiv_arbiter_pkg;

    localparam int unsigned OP_W   = 32;
    localparam int unsigned FN_W   = 3;
    localparam int unsigned REQ_W  = FN_W + 2 * OP_W;
    localparam int unsigned RESP_W = 2 * OP_W;

    localparam int unsigned B_LSB  = 0;
    localparam int unsigned A_LSB  = OP_W;
    localparam int unsigned FN_LSB = 2 * OP_W;

    localparam logic [FN_W-1:0] FN_MUL  = 3'd0;
    localparam logic [FN_W-1:0] FN_DIV  = 3'd1;
    localparam logic [FN_W-1:0] FN_DIVU = 3'd2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/imuldiv_rr_arb2.sv
// Two-way round-robin pick: a lone valid wins, otherwise prio breaks the tie.
module imuldiv_rr_arb2 (
    input  logic [1:0] val,
    input  logic       prio,
    output logic       grant,
    output logic       any
);

    always_comb begin
        any   = |val;
        grant = (val == 2'b11) ? prio : val[1];
    end

endmodule

// File: rtl/imuldiv_muldiv_arbiter.sv
// Shares one iterative mul/div unit between two val/rdy requesters, one op at a time.
// Define IMULDIV_ARB_PERF_EN to add the perf_grant0/perf_grant1/perf_busy counters.
module imuldiv_muldiv_arbiter
    import imuldiv_muldiv_arbiter_pkg::*;
`ifdef IMULDIV_ARB_PERF_EN
#(
    parameter int unsigned CNT_W = 32
)
`endif
(
    input  logic              clk,
    input  logic              reset,

    input  logic [REQ_W-1:0]  req0_msg,
    input  logic              req0_val,
    output logic              req0_rdy,
    output logic [RESP_W-1:0] resp0_msg,
    output logic              resp0_val,
    input  logic              resp0_rdy,

    input  logic [REQ_W-1:0]  req1_msg,
    input  logic              req1_val,
    output logic              req1_rdy,
    output logic [RESP_W-1:0] resp1_msg,
    output logic              resp1_val,
    input  logic              resp1_rdy,

    output logic [REQ_W-1:0]  muldivreq_msg,
    output logic              muldivreq_val,
    input  logic              muldivreq_rdy,
    input  logic [RESP_W-1:0] muldivresp_msg,
    input  logic              muldivresp_val,
    output logic              muldivresp_rdy
`ifdef IMULDIV_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_grant0,
    output logic [CNT_W-1:0]  perf_grant1,
    output logic [CNT_W-1:0]  perf_busy
`endif
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       prio_q, prio_d;
    logic       grant, any;
    logic       req_fire, resp_fire;

    imuldiv_rr_arb2 u_rr_arb2 (
        .val   ({req1_val, req0_val}),
        .prio  (prio_q),
        .grant (grant),
        .any   (any)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        prio_d         = prio_q;
        muldivreq_msg  = '0;
        muldivreq_val  = 1'b0;
        req0_rdy       = 1'b0;
        req1_rdy       = 1'b0;
        resp0_val      = 1'b0;
        resp1_val      = 1'b0;
        muldivresp_rdy = 1'b0;
        req_fire       = 1'b0;
        resp_fire      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (any) begin
                    owner_d = grant;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                muldivreq_msg = owner_q ? req1_msg : req0_msg;
                muldivreq_val = owner_q ? req1_val : req0_val;
                req0_rdy      = !owner_q && muldivreq_rdy;
                req1_rdy      = owner_q && muldivreq_rdy;
                req_fire      = muldivreq_val && muldivreq_rdy;
                if (req_fire) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                resp0_val      = !owner_q && muldivresp_val;
                resp1_val      = owner_q && muldivresp_val;
                muldivresp_rdy = owner_q ? resp1_rdy : resp0_rdy;
                resp_fire      = muldivresp_val && muldivresp_rdy;
                if (resp_fire) begin
                    prio_d  = ~owner_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Handshakes are squashed combinationally while reset is held low.
        if (!reset) begin
            muldivreq_val  = 1'b0;
            req0_rdy       = 1'b0;
            req1_rdy       = 1'b0;
            resp0_val      = 1'b0;
            resp1_val      = 1'b0;
            muldivresp_rdy = 1'b0;
            req_fire       = 1'b0;
            resp_fire      = 1'b0;
        end
    end

    assign resp0_msg = resp0_val ? muldivresp_msg : '0;
    assign resp1_msg = resp1_val ? muldivresp_msg : '0;

`ifdef IMULDIV_ARB_PERF_EN
    logic [CNT_W-1:0] grant0_q, grant1_q, busy_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            grant0_q <= '0;
            grant1_q <= '0;
            busy_q   <= '0;
        end else begin
            if (req_fire && !owner_q) grant0_q <= grant0_q + CNT_W'(1);
            if (req_fire && owner_q)  grant1_q <= grant1_q + CNT_W'(1);
            if (state_q != StIdle)    busy_q   <= busy_q + CNT_W'(1);
        end
    end

    assign perf_grant0 = grant0_q;
    assign perf_grant1 = grant1_q;
    assign perf_busy   = busy_q;
`endif

endmodule

// File: tb/tb_imuldiv_muldiv_arbiter.sv
// Bench for imuldiv_muldiv_arbiter: two queue-fed requesters, random-ready sinks and a
// fixed-latency behavioural mul/div unit; responses are checked against a scoreboard.
`timescale 1ns/1ps
module tb_imuldiv_muldiv_arbiter;
    import imuldiv_muldiv_arbiter_pkg::*;

    localparam int unsigned LAT    = 4;
    localparam int          BUDGET = 2000;

    logic              clk = 1'b0;
    logic              reset;
    logic [REQ_W-1:0]  req0_msg, req1_msg, muldivreq_msg;
    logic              req0_val, req0_rdy, req1_val, req1_rdy;
    logic [RESP_W-1:0] resp0_msg, resp1_msg, muldivresp_msg;
    logic              resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic              muldivreq_val, muldivreq_rdy, muldivresp_val, muldivresp_rdy;
`ifdef IMULDIV_ARB_PERF_EN
    logic [31:0]       perf_grant0, perf_grant1, perf_busy;
`endif

    int tests = 0;
    int fails = 0;

    logic [REQ_W-1:0]  src0_q[$], src1_q[$];
    logic [RESP_W-1:0] exp0_q[$], exp1_q[$];
    bit                grant_log[$];
    int                g0_cnt = 0, g1_cnt = 0;
    bit                resp1_seen = 1'b0;
    bit                rand_rdy = 1'b0, stall0 = 1'b0;

    always #5 clk = ~clk;

    imuldiv_muldiv_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req0_msg       (req0_msg),
        .req0_val       (req0_val),
        .req0_rdy       (req0_rdy),
        .resp0_msg      (resp0_msg),
        .resp0_val      (resp0_val),
        .resp0_rdy      (resp0_rdy),
        .req1_msg       (req1_msg),
        .req1_val       (req1_val),
        .req1_rdy       (req1_rdy),
        .resp1_msg      (resp1_msg),
        .resp1_val      (resp1_val),
        .resp1_rdy      (resp1_rdy),
        .muldivreq_msg  (muldivreq_msg),
        .muldivreq_val  (muldivreq_val),
        .muldivreq_rdy  (muldivreq_rdy),
        .muldivresp_msg (muldivresp_msg),
        .muldivresp_val (muldivresp_val),
        .muldivresp_rdy (muldivresp_rdy)
`ifdef IMULDIV_ARB_PERF_EN
        ,
        .perf_grant0    (perf_grant0),
        .perf_grant1    (perf_grant1),
        .perf_busy      (perf_busy)
`endif
    );

    // Result layout of the shared unit: {remainder, quotient} for divides.
    function automatic logic [RESP_W-1:0] unit_model(input logic [REQ_W-1:0] m);
        logic [FN_W-1:0] fn;
        logic [OP_W-1:0] a, b, lo, hi;
        fn = m[FN_LSB +: FN_W];
        a  = m[A_LSB +: OP_W];
        b  = m[B_LSB +: OP_W];
        hi = '0;
        if (fn == FN_MUL) begin
            lo = a * b;
        end else if (b == '0) begin
            lo = '1;
            hi = a;
        end else if (fn == FN_DIV) begin
            lo = $signed(a) / $signed(b);
            hi = $signed(a) % $signed(b);
        end else begin
            lo = a / b;
            hi = a % b;
        end
        return {hi, lo};
    endfunction

    task automatic send(input bit which, input logic [REQ_W-1:0] m,
                        input logic [RESP_W-1:0] e);
        if (which) begin
            src1_q.push_back(m);
            exp1_q.push_back(e);
        end else begin
            src0_q.push_back(m);
            exp0_q.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((src0_q.size() + src1_q.size() + exp0_q.size() + exp1_q.size()) != 0
               && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        tests++;
        assert (n < BUDGET) else begin
            fails++;
            $error("FAIL %s_drain: %0d items outstanding, required 0", tag,
                   exp0_q.size() + exp1_q.size());
        end
    endtask

    task automatic wait_resp0(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (resp0_val !== 1'b1 && n < BUDGET);
        tests++;
        assert (resp0_val === 1'b1) else begin
            fails++;
            $error("FAIL %s_wait: resp0_val=%b, required 1", tag, resp0_val);
        end
    endtask

    task automatic check_grants(input string tag, input int n0, input int n1);
        tests++;
        assert (grant_log.size() == 2 && grant_log[0] == 1'(n0) && grant_log[1] == 1'(n1))
        else begin
            fails++;
            $error("FAIL %s_grants: got %p, required '{%0d,%0d}", tag, grant_log, n0, n1);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        logic [5:0] hs;
        hs = {req0_rdy, req1_rdy, resp0_val, resp1_val, muldivreq_val, muldivresp_rdy};
        tests++;
        assert (hs === 6'b0) else begin
            fails++;
            $error("FAIL %s_handshakes: got %b, required 000000", tag, hs);
        end
    endtask

    initial begin : src0_drv
        bit go;
        req0_val = 1'b0;
        req0_msg = '0;
        forever begin
            @(negedge clk);
            go = req0_val && req0_rdy;
            @(posedge clk);
            #1;
            if (go && src0_q.size() > 0) src0_q.delete(0);
            req0_val = src0_q.size() > 0;
            if (req0_val) req0_msg = src0_q[0];
            else          req0_msg = '0;
        end
    end

    initial begin : src1_drv
        bit go;
        req1_val = 1'b0;
        req1_msg = '0;
        forever begin
            @(negedge clk);
            go = req1_val && req1_rdy;
            @(posedge clk);
            #1;
            if (go && src1_q.size() > 0) src1_q.delete(0);
            req1_val = src1_q.size() > 0;
            if (req1_val) req1_msg = src1_q[0];
            else          req1_msg = '0;
        end
    end

    initial begin : sink_drv
        resp0_rdy = 1'b1;
        resp1_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            resp0_rdy = stall0 ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            resp1_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : unit_drv
        bit               rq_fire, rs_fire, rst_s, busy;
        int               cnt;
        logic [REQ_W-1:0] rq_msg;
        logic [RESP_W-1:0] res;
        busy = 1'b0;
        cnt  = 0;
        res  = '0;
        muldivreq_rdy  = 1'b1;
        muldivresp_val = 1'b0;
        muldivresp_msg = '0;
        forever begin
            @(negedge clk);
            rq_fire = muldivreq_val && muldivreq_rdy;
            rs_fire = muldivresp_val && muldivresp_rdy;
            rq_msg  = muldivreq_msg;
            rst_s   = reset;
            @(posedge clk);
            #1;
            if (!rst_s) begin
                busy = 1'b0;
            end else begin
                if (rs_fire)                busy = 1'b0;
                else if (busy && cnt != 0)  cnt--;
                if (rq_fire) begin
                    busy = 1'b1;
                    cnt  = LAT;
                    res  = unit_model(rq_msg);
                end
            end
            muldivreq_rdy  = !busy;
            muldivresp_val = busy && cnt == 0;
            muldivresp_msg = muldivresp_val ? res : '0;
        end
    end

    always @(negedge clk) begin
        logic [RESP_W-1:0] e;
        if (reset === 1'b1) begin
            if (resp1_val) resp1_seen = 1'b1;
            if (muldivreq_val && muldivreq_rdy) begin
                grant_log.push_back(req1_rdy);
                if (req1_rdy) g1_cnt++;
                else          g0_cnt++;
                tests++;
                assert ((req0_rdy ^ req1_rdy) &&
                        muldivreq_msg === (req1_rdy ? req1_msg : req0_msg)) else begin
                    fails++;
                    $error("FAIL issue_msg: got %h (rdy %b%b), required owner message",
                           muldivreq_msg, req1_rdy, req0_rdy);
                end
            end
            if (resp0_val && resp0_rdy) begin
                e = (exp0_q.size() > 0) ? exp0_q.pop_front() : 'x;
                tests++;
                assert (resp0_msg === e) else begin
                    fails++;
                    $error("FAIL resp0: got %h, required %h", resp0_msg, e);
                end
            end
            if (resp1_val && resp1_rdy) begin
                e = (exp1_q.size() > 0) ? exp1_q.pop_front() : 'x;
                tests++;
                assert (resp1_msg === e) else begin
                    fails++;
                    $error("FAIL resp1: got %h, required %h", resp1_msg, e);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [OP_W-1:0]  a, b;
        logic [REQ_W-1:0] m;
        int               bad;

        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #2 reset = 1'b1;

        // Single requester 0; requester 1 must never see a response.
        resp1_seen = 1'b0;
        send(0, 67'h0_00000008_00000003, 64'h00000000_00000018);
        drain("t1");
        tests++;
        assert (resp1_seen === 1'b0 && grant_log.size() == 1 && grant_log[0] == 1'b0) else begin
            fails++;
            $error("FAIL t1_owner: resp1_seen=%b grants=%p, required 0 and '{0}",
                   resp1_seen, grant_log);
        end
        grant_log.delete();

        send(1, 67'h1_00000222_0000002a, 64'h00000000_0000000d);
        drain("t2");
        tests++;
        assert (grant_log.size() == 1 && grant_log[0] == 1'b1) else begin
            fails++;
            $error("FAIL t2_owner: grants=%p, required '{1}", grant_log);
        end
        grant_log.delete();

        // Simultaneous requests: prio favours requester 0.
        send(0, 67'h0_00000001_00000001, 64'h00000000_00000001);
        send(1, 67'h1_00000222_00000032, 64'h0000002e_0000000a);
        drain("t3");
        check_grants("t3", 0, 1);
        grant_log.delete();

        // Two 8-op streams with random sink back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = $urandom();
            b = $urandom_range(1, 32'hffff);
            m = {FN_MUL, a, b};
            send(0, m, unit_model(m));
            m = {((i % 2) != 0) ? FN_DIVU : FN_DIV, a, b};
            send(1, m, unit_model(m));
        end
        drain("t4");
        rand_rdy = 1'b0;
        tests++;
        assert (grant_log.size() == 16) else begin
            fails++;
            $error("FAIL t4_count: got %0d grants, required 16", grant_log.size());
        end
        for (int i = 0; i < grant_log.size(); i++) begin
            tests++;
            assert (grant_log[i] == 1'(i % 2)) else begin
                fails++;
                $error("FAIL t4_alternate[%0d]: got %0d, required %0d", i, grant_log[i], i % 2);
            end
        end
        grant_log.delete();

        // Owner 0 stalls its response; requester 1 must wait and nothing is lost.
        stall0 = 1'b1;
        send(0, 67'h0_00000007_00000006, 64'h00000000_0000002a);
        wait_resp0("t5");
        send(1, 67'h2_00000064_00000007, 64'h00000002_0000000e);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (muldivresp_rdy !== 1'b0 || req1_rdy !== 1'b0 || resp0_val !== 1'b1) bad++;
        end
        tests++;
        assert (bad == 0) else begin
            fails++;
            $error("FAIL t5_stall: got %0d bad cycles, required 0", bad);
        end
        stall0 = 1'b0;
        drain("t5");
        check_grants("t5", 0, 1);

        // Complete a requester-0 op so prio points at 1, then reset mid-WAIT.
        send(0, 67'h0_00000002_00000002, 64'h00000000_00000004);
        drain("t6a");
        stall0 = 1'b1;
        send(0, 67'h0_00000009_00000009, 64'h00000000_00000051);
        wait_resp0("t6");
        @(posedge clk);
        #2 reset = 1'b0;
        src0_q.delete();
        exp0_q.delete();
        @(negedge clk);
        check_idle_outputs("t6_in_reset");
        stall0 = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("t6_released");
`ifdef IMULDIV_ARB_PERF_EN
        tests++;
        assert ({perf_grant0, perf_grant1, perf_busy} === 96'h0) else begin
            fails++;
            $error("FAIL t6_perf_clear: got %0d/%0d/%0d, required 0/0/0",
                   perf_grant0, perf_grant1, perf_busy);
        end
`endif
        g0_cnt = 0;
        g1_cnt = 0;
        grant_log.delete();
        send(0, 67'h2_aaaaaaaa_00000005, 64'h00000000_22222222);
        send(1, 67'h0_00000003_00000005, 64'h00000000_0000000f);
        drain("t6");
        check_grants("t6", 0, 1);
`ifdef IMULDIV_ARB_PERF_EN
        @(negedge clk);
        tests++;
        assert (perf_grant0 === 32'(g0_cnt) && perf_grant1 === 32'(g1_cnt) &&
                perf_grant0 === 32'd1 && perf_grant1 === 32'd1) else begin
            fails++;
            $error("FAIL t6_perf_grants: got %0d/%0d, required 1/1", perf_grant0, perf_grant1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
